// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Drives a 4-digit, common-anode, multiplexed 7-segment display.
// The display shows the 16-bit value {A0M, A0L} as four hex digits.
// Digits are scanned 0 -> 1 -> 2 -> 3. Each digit slot is SCAN_DIV cycles long.
// Each slot begins with BLANK_CYCLES cycles of all-anodes-off to prevent ghosting.
// The inputs are copied into a shadow register once per frame, so one frame
// never mixes old and new values.
// Parameter constraints: BLANK_CYCLES >= 1 and SCAN_DIV >= BLANK_CYCLES+1.
// Optional feature: define SEG7_LZB_EN to enable leading-zero blanking of digits 3..1.
module seg7_scan_driver #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] A0M,
  input  logic [7:0] A0L,
  output logic [7:0] seg,
  output logic [3:0] anx
);

  localparam int              CNT_W    = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ON   = CNT_W'(BLANK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_SNAP = CNT_W'(BLANK_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic [1:0]       idx;
  logic [1:0]       idx_nx;
  logic [15:0]      shadow;
  logic [15:0]      shadow_nx;
  logic             snap;
  logic             lead_zero;
  logic             lit;
  logic [3:0]       nib;

  // Map a hex nibble to active-low gfedcba segments.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Compute the next scan position and snapshot.
  // The outputs are registered from these next values, so they match cnt/idx after each edge.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default value first.
    // Without a default, any path that skips an assignment would infer a latch.
    cnt_nx    = cnt + 1'b1;
    idx_nx    = idx;
    lead_zero = 1'b0;
    if (cnt == CNT_LAST) begin
      cnt_nx = '0;
      idx_nx = idx + 2'd1;
    end
    // Capture the inputs as digit0's lit phase begins, so digit0 shows the new value immediately.
    snap      = (idx == 2'd0) && (cnt == CNT_SNAP);
    shadow_nx = snap ? {A0M, A0L} : shadow;
    nib       = shadow_nx[{idx_nx, 2'b00} +: 4];
`ifdef SEG7_LZB_EN
    // A digit is blanked when it and every higher digit are zero. Digit0 is never blanked.
    case (idx_nx)
      2'd3:    lead_zero = (shadow_nx[15:12] == 4'h0);
      2'd2:    lead_zero = (shadow_nx[15:8]  == 8'h00);
      2'd1:    lead_zero = (shadow_nx[15:4]  == 12'h000);
      default: lead_zero = 1'b0;
    endcase
`endif
    lit = (cnt_nx >= CNT_ON) && !lead_zero;
  end

  // Register the scan state, the shadow copy and the display outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      idx    <= 2'd0;
      shadow <= 16'h0000;
      anx    <= 4'b1111;
      seg    <= 8'hFF;
    end else begin
      // NOTE: sequential state uses non-blocking assignments.
      // This ensures every register samples values from before the clock edge.
      cnt    <= cnt_nx;
      idx    <= idx_nx;
      shadow <= shadow_nx;
      if (lit) begin
        anx <= ~(4'b0001 << idx_nx);
        seg <= {1'b1, hex_to_seg(nib)};
      end else begin
        anx <= 4'b1111;
        seg <= 8'hFF;
      end
    end
  end

endmodule
